// File: rtl/dw_window_gen_if.sv
// Pixel-in / window-out bundle for dw_window_gen.
// The master side is the pixel producer that also consumes the windows.
// The slave side is the window generator.
interface dw_window_gen_if #(
    parameter int CH    = 16,
    parameter int ACT_W = 16
);
    logic                     in_valid;
    logic [CH*ACT_W-1:0]      in_act;
    logic                     out_valid;
    logic [CH*9*ACT_W-1:0]    out_act;
    logic                     frame_done;

    modport master (
        output in_valid, in_act,
        input  out_valid, out_act, frame_done
    );

    modport slave (
        input  in_valid, in_act,
        output out_valid, out_act, frame_done
    );
endinterface

// File: rtl/dw_window_gen.sv
// 3x3 sliding-window generator for a depthwise conv layer.
// Pixels arrive in raster order. Two line buffers supply the two rows above
// the incoming pixel, and a per-channel 3x3 shift register forms the window.
// A window is emitted one cycle after each pixel at (r>=2, c>=2). That gating
// keeps stale line-buffer data and wrapped right-edge columns out of every
// emitted window.
module dw_window_gen #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int CH    = 16,
    parameter int ACT_W = 16
) (
    input  logic            clk,
    input  logic            rstn,
    dw_window_gen_if.slave  bus
);
    localparam int PIX_W = CH * ACT_W;
    localparam int CW    = $clog2(IMG_W);
    localparam int RW    = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    // Raster position of the pixel currently presented on in_act.
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;

    // Line buffers: lb1 holds row r-1 and lb2 holds row r-2, indexed by column.
    logic [PIX_W-1:0] lb1_q [IMG_W];
    logic [PIX_W-1:0] lb2_q [IMG_W];
    logic [PIX_W-1:0] up1, up2;

    // Window taps are [channel][k], with k = 3*row + col and 0 = oldest.
    // This packed layout is the out_act bit layout.
    logic [CH-1:0][8:0][ACT_W-1:0] win_q, win_d;
    logic [CH-1:0][8:0][ACT_W-1:0] out_act_q;
    logic                          out_valid_q;
    logic                          frame_done_q;

    logic win_ok;
    logic frame_last;

    assign up1 = lb1_q[col_q];
    assign up2 = lb2_q[col_q];

    assign win_ok     = bus.in_valid && (row_q >= RW'(2)) && (col_q >= CW'(2));
    assign frame_last = win_ok && (row_q == ROW_LAST) && (col_q == COL_LAST);

    // Next raster position: column wraps into the next row, last pixel wraps the frame.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (bus.in_valid) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    // Shift every window row left by one tap.
    // The new right-hand column is the two pixels above plus the incoming pixel.
    always_comb begin
        win_d = win_q;
        for (int c = 0; c < CH; c++) begin
            for (int r = 0; r < 3; r++) begin
                win_d[c][3*r]     = win_q[c][3*r+1];
                win_d[c][3*r+1]   = win_q[c][3*r+2];
            end
            win_d[c][2] = up2[ACT_W*c +: ACT_W];
            win_d[c][5] = up1[ACT_W*c +: ACT_W];
            win_d[c][8] = bus.in_act[ACT_W*c +: ACT_W];
        end
    end

    // Counters, window and output registers.
    // Everything holds on idle cycles. A window is captured only when complete.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            col_q        <= '0;
            row_q        <= '0;
            win_q        <= '0;
            out_act_q    <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            out_valid_q  <= win_ok;
            frame_done_q <= frame_last;
            if (bus.in_valid) begin
                win_q <= win_d;
            end
            if (win_ok) begin
                out_act_q <= win_d;
            end
        end
    end

    // Line buffers age by one row at the current column.
    // They are left unreset because the row>=2 gate hides their old contents.
    always_ff @(posedge clk) begin
        if (rstn && bus.in_valid) begin
            lb1_q[col_q] <= bus.in_act;
            lb2_q[col_q] <= lb1_q[col_q];
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_act    = out_act_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: doc/dw_window_gen.md
DW_WINDOW_GEN -- requirements
Module: dw_window_gen

Interface
REQ-001 The block SHALL have a parameter IMG_W, default 8, giving the input feature-map width in pixels (minimum 3).
REQ-002 The block SHALL have a parameter IMG_H, default 8, giving the input feature-map height in pixels (minimum 3).
REQ-003 The block SHALL have a parameter CH, default 16, giving the channels per pixel.
REQ-004 The block SHALL have a parameter ACT_W, default 16, giving the bits per activation (signed).
REQ-005 The block SHALL have a port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-006 The block SHALL have a port rstn, input, 1 bit: reset, synchronous and active-low.
REQ-007 The block SHALL have a port in_valid, input, 1 bit: in_act carries one pixel this cycle.
REQ-008 The block SHALL have a port in_act, input, CH*ACT_W bits: one pixel, channel c at bits [ACT_W*c +: ACT_W].
REQ-009 The block SHALL have a port out_valid, output, 1 bit: out_act holds a complete 3x3 window, asserted for exactly one cycle per window.
REQ-010 The block SHALL have a port out_act, output, CH*9*ACT_W bits: 3x3 window for all channels, in the depthwise-layer input format.
REQ-011 The block SHALL have a port frame_done, output, 1 bit: one-cycle pulse, coincident with the out_valid of the last window of a frame.

Function
REQ-012 The block SHALL accept pixels in raster order (row 0 first, left to right) with stride 1 and no padding, and SHALL emit (IMG_H-2)*(IMG_W-2) windows per frame.
REQ-013 The block SHALL keep a column counter (0..IMG_W-1) and a row counter (0..IMG_H-1) that advance only on cycles where in_valid=1; the column SHALL wrap to 0 with row+1, and after pixel (IMG_H-1, IMG_W-1) both SHALL return to 0 so the next frame starts with no idle cycle.
REQ-014 Cycles with in_valid=0 SHALL leave the counters, line buffers and window registers unchanged, and out_valid SHALL be 0 on the following cycle.
REQ-015 The block SHALL hold two line buffers of IMG_W pixels each, for rows r-1 and r-2, plus a 3x3 shift-register window per channel.
REQ-016 When in_valid=1 delivers pixel (r,c) with r>=2 and c>=2, out_valid SHALL be 1 on the next cycle, and out_act SHALL hold the window with rows r-2..r and columns c-2..c.
REQ-017 In all other cases out_valid SHALL be 0, and out_act SHALL hold its last value.
REQ-018 The packing of out_act SHALL place channel c at bits [9*ACT_W*c +: 9*ACT_W].
REQ-019 Within a channel, tap k SHALL be at bits [ACT_W*k +: ACT_W] with k = 3*wr + wc, where wr=0 is the top (oldest) row and wc=0 is the left (oldest) column.
REQ-020 The window for a new row SHALL be built only from pixels of that row and the two rows above; no data from the previous row's right edge SHALL appear in it, which the c>=2 condition guarantees.
REQ-021 Line-buffer contents of the previous frame SHALL NOT contribute to any window of a new frame, which the r>=2 condition guarantees.
REQ-022 The block SHALL have no backpressure; the downstream layer SHALL consume out_act in the cycle that out_valid=1.
REQ-023 Activations SHALL be moved bit-exact, with no arithmetic, sign change or truncation.

Reset
REQ-024 While rstn=0 at a rising edge, the block SHALL clear out_valid, frame_done, out_act, the row counter, the column counter and the window registers to 0.
REQ-025 Line-buffer storage SHALL NOT require reset.
REQ-026 A reset asserted mid-frame SHALL abandon that frame; the first in_valid pixel after rstn returns to 1 SHALL be taken as pixel (0,0) of a new frame.
REQ-027 An in_valid=1 pixel presented in a cycle with rstn=0 SHALL be ignored.

Verification
(All scenarios use IMG_W=IMG_H=4, CH=16, ACT_W=16. Pixel p = 4r+c has channel ch value 16p+ch.)
REQ-028 Streaming 16 pixels back-to-back -> out_valid high on the cycles after pixels 10, 11, 14 and 15 only; frame_done only with the last of these.
REQ-029 For the first window, channel 0 -> tap0=0, tap4=80, tap8=160; for channel 15 -> tap0=15, tap8=175.
REQ-030 Same frame with in_valid=0 inserted between every pixel -> the same 4 windows with identical contents, and no out_valid during the gaps.
REQ-031 Two frames streamed back-to-back, frame 2 values +1000 -> 8 windows; window 5 tap0 ch0=1000, with no frame-1 data in any frame-2 window.
REQ-032 rstn=0 for one cycle after pixel 9, then a full frame -> no window from the aborted frame; out_act=0 after reset; then the 4 correct windows.
REQ-033 Random in_valid (50%) over 3 frames, checked against a software sliding-window model -> every window bit-exact and the window count equals 12.
